// File: rtl/and3_exhaustive_checker.sv
// Exhaustive self-checking sequencer for the three-input AND gate.
// Drives every {a,b,c} combination, lets the gate settle, then compares d/e against the golden function.
module and3_exhaustive_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_d,
  input  logic       dut_e,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_FINISH
  } state_t;

  // WAIT lasts SETTLE_CYCLES cycles: the counter is loaded with one less and exits at zero.
  localparam logic [3:0] WAIT_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam bit         NO_WAIT   = (SETTLE_CYCLES == 0);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [2:0] drv_vec;
  logic [3:0] wait_cnt;
  logic       vec_mismatch;

  function automatic logic golden_d(input logic [2:0] v);
    return v[2] & v[1];
  endfunction

  function automatic logic golden_e(input logic [2:0] v);
    return v[2] & v[1] & v[0];
  endfunction

  function automatic logic outputs_differ(input logic [2:0] v, input logic d, input logic e);
    return (d != golden_d(v)) || (e != golden_e(v));
  endfunction

  assign drv_a        = drv_vec[2];
  assign drv_b        = drv_vec[1];
  assign drv_c        = drv_vec[0];
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_FINISH);
  assign vec_mismatch = outputs_differ(drv_vec, dut_d, dut_e);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_APPLY;
      S_APPLY:  state_nxt = NO_WAIT ? S_CHECK : S_WAIT;
      S_WAIT:   if (wait_cnt == 4'd0) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = (idx == 3'd7) ? S_FINISH : S_APPLY;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx              <= 3'd0;
      drv_vec          <= 3'd0;
      wait_cnt         <= 4'd0;
      err_count        <= 4'd0;
      pass             <= 1'b0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx              <= 3'd0;
            drv_vec          <= 3'd0;
            err_count        <= 4'd0;
            pass             <= 1'b0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
          end
        end
        S_APPLY: wait_cnt <= WAIT_LOAD;
        S_WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        S_CHECK: begin
          if (vec_mismatch) begin
            err_count <= err_count + 4'd1;
            if (!first_fail_valid) begin
              first_fail_vec   <= idx;
              first_fail_valid <= 1'b1;
            end
          end
          // The next vector's drive is registered on the same edge that enters APPLY.
          if (idx != 3'd7) begin
            idx     <= idx + 3'd1;
            drv_vec <= idx + 3'd1;
          end
        end
        S_FINISH: begin
          pass    <= (err_count == 4'd0);
          idx     <= 3'd0;
          drv_vec <= 3'd0;
        end
        default: begin
          idx     <= 3'd0;
          drv_vec <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and3_exhaustive_checker.sv
// Directed bench: two checker instances (default settle and zero settle) beside a behavioural AND gate with injectable faults.
module tb_and3_exhaustive_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: SETTLE_CYCLES = 2
  logic       a_start = 1'b0;
  int         a_fault = 0;
  logic       a_dut_d, a_dut_e, a_drv_a, a_drv_b, a_drv_c, a_busy, a_done, a_pass, a_ffv;
  logic [3:0] a_err;
  logic [2:0] a_ffvec;

  // Instance B: SETTLE_CYCLES = 0
  logic       b_start = 1'b0;
  int         b_fault = 0;
  logic       b_dut_d, b_dut_e, b_drv_a, b_drv_b, b_drv_c, b_busy, b_done, b_pass, b_ffv;
  logic [3:0] b_err;
  logic [2:0] b_ffvec;

  // fault 1: e stuck at 0, fault 2: d stuck at 1
  assign a_dut_d = (a_fault == 2) ? 1'b1 : (a_drv_a & a_drv_b);
  assign a_dut_e = (a_fault == 1) ? 1'b0 : (a_drv_a & a_drv_b & a_drv_c);
  assign b_dut_d = (b_fault == 2) ? 1'b1 : (b_drv_a & b_drv_b);
  assign b_dut_e = (b_fault == 1) ? 1'b0 : (b_drv_a & b_drv_b & b_drv_c);

  and3_exhaustive_checker #(.SETTLE_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .dut_d(a_dut_d), .dut_e(a_dut_e),
    .drv_a(a_drv_a), .drv_b(a_drv_b), .drv_c(a_drv_c), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .first_fail_vec(a_ffvec), .first_fail_valid(a_ffv)
  );

  and3_exhaustive_checker #(.SETTLE_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .dut_d(b_dut_d), .dut_e(b_dut_e),
    .drv_a(b_drv_a), .drv_b(b_drv_b), .drv_c(b_drv_c), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err), .first_fail_vec(b_ffvec), .first_fail_valid(b_ffv)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run on instance A with a start pulse; optional start pulses during vector 3.
  task automatic run_a(input string tag, input bit kick, input logic [3:0] e_err,
                       input logic e_pass, input logic e_ffv, input logic [2:0] e_ffvec);
    int          cyc;
    int          done_cyc;
    logic [23:0] seq;
    a_start = 1'b1;
    tick();
    a_start  = 1'b0;
    cyc      = 1;
    done_cyc = 0;
    seq      = '0;
    chk({tag, "_busy_first"}, 32'(a_busy), 32'd1);
    while (done_cyc == 0 && cyc < 100) begin
      if (((cyc - 1) % 4 == 0) && cyc <= 29) seq = {seq[20:0], a_drv_a, a_drv_b, a_drv_c};
      if (a_done) done_cyc = cyc;
      else begin
        a_start = kick && (cyc >= 13) && (cyc <= 16);
        tick();
        cyc++;
      end
    end
    a_start = 1'b0;
    chk({tag, "_drv_seq"}, 32'(seq), 32'o01234567);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'd33);
    chk({tag, "_busy_finish"}, 32'(a_busy), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(a_done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(a_busy), 32'd0);
    chk({tag, "_drv_idle"}, 32'({a_drv_a, a_drv_b, a_drv_c}), 32'd0);
    chk({tag, "_err"}, 32'(a_err), 32'(e_err));
    chk({tag, "_pass"}, 32'(a_pass), 32'(e_pass));
    chk({tag, "_ffv"}, 32'(a_ffv), 32'(e_ffv));
    chk({tag, "_ffvec"}, 32'(a_ffvec), 32'(e_ffvec));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_drv", 32'({a_drv_a, a_drv_b, a_drv_c}), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_pass", 32'(a_pass), 32'd0);
    chk("rst_ffv", 32'(a_ffv), 32'd0);
    rst = 1'b0;
    tick();

    run_a("good", 1'b0, 4'd0, 1'b1, 1'b0, 3'd0);
    repeat (3) tick();
    chk("held_pass", 32'(a_pass), 32'd1);

    a_fault = 1;
    run_a("e_stuck0", 1'b0, 4'd1, 1'b0, 1'b1, 3'd7);
    a_fault = 2;
    run_a("d_stuck1", 1'b0, 4'd6, 1'b0, 1'b1, 3'd0);
    a_fault = 0;
    run_a("kick", 1'b1, 4'd0, 1'b1, 1'b0, 3'd0);

    // Reset during the WAIT of vector 4 (cycle 18 after the accept edge).
    a_fault = 2;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (17) tick();
    chk("midrun_err", 32'(a_err), 32'd4);
    chk("midrun_drv", 32'({a_drv_a, a_drv_b, a_drv_c}), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(a_busy), 32'd0);
    chk("mrst_done", 32'(a_done), 32'd0);
    chk("mrst_drv", 32'({a_drv_a, a_drv_b, a_drv_c}), 32'd0);
    chk("mrst_err", 32'(a_err), 32'd0);
    chk("mrst_ffv", 32'(a_ffv), 32'd0);
    chk("mrst_pass", 32'(a_pass), 32'd0);
    a_fault = 0;
    tick();
    run_a("post_rst", 1'b0, 4'd0, 1'b1, 1'b0, 3'd0);

    // Zero-settle instance, start held high across three back-to-back runs.
    b_start = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 54; cyc++) begin
      case (cyc)
        3:  chk("z_drv_v1", 32'({b_drv_a, b_drv_b, b_drv_c}), 32'd1);
        15: chk("z_drv_v7", 32'({b_drv_a, b_drv_b, b_drv_c}), 32'd7);
        16: chk("z_done_early", 32'(b_done), 32'd0);
        17: chk("z_done1", 32'(b_done), 32'd1);
        18: begin
          chk("z_pass1", 32'(b_pass), 32'd1);
          chk("z_idle_busy", 32'(b_busy), 32'd0);
          b_fault = 2;
        end
        19: begin
          chk("z_restart_busy", 32'(b_busy), 32'd1);
          chk("z_pass_clr", 32'(b_pass), 32'd0);
        end
        35: chk("z_done2", 32'(b_done), 32'd1);
        36: begin
          chk("z_err2", 32'(b_err), 32'd6);
          chk("z_ffv2", 32'(b_ffv), 32'd1);
          chk("z_ffvec2", 32'(b_ffvec), 32'd0);
          b_fault = 0;
        end
        37: begin
          chk("z_err_clr", 32'(b_err), 32'd0);
          chk("z_ffv_clr", 32'(b_ffv), 32'd0);
        end
        53: begin
          chk("z_done3", 32'(b_done), 32'd1);
          b_start = 1'b0;
        end
        54: begin
          chk("z_pass3", 32'(b_pass), 32'd1);
          chk("z_busy3", 32'(b_busy), 32'd0);
        end
        default: ;
      endcase
      if (cyc < 54) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/and3_exhaustive_checker.md
Name: and3_exhaustive_checker

Overview:
- Self-checking sequencer for the three-input AND gate datapath (inputs a,b,c; outputs d = a&b, e = a&b&c).
- On a start pulse it drives all 8 input combinations into the gate in binary order and waits a programmable settle time per vector.
- It samples d and e, compares them against the golden function, and reports an error count, the first failing vector and pass/fail.
- It sits beside the gate instance on the lab board or bench, in place of the free-running delay-toggle stimulus.

Parameters:
- SETTLE_CYCLES, 2, number of WAIT cycles between applying a vector and sampling the outputs; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- dut_d  input  1  gate output d.
- dut_e  input  1  gate output e.
- drv_a  output  1  drive to gate input a; registered.
- drv_b  output  1  drive to gate input b; registered.
- drv_c  output  1  drive to gate input c; registered.
- busy  output  1  high from the first APPLY through FINISH inclusive.
- done  output  1  one-cycle pulse in FINISH.
- pass  output  1  high when the last completed run had zero mismatches; held until the next accepted start.
- err_count  output  4  number of mismatching vectors in the current or last run (0..8).
- first_fail_vec  output  3  index {a,b,c} of the first mismatching vector.
- first_fail_valid  output  1  high when first_fail_vec is meaningful.

Behaviour:
- Reset (rst=1 at a clock edge, from any state including mid-run):
  - state=IDLE, vector index idx=0.
  - drv_a/b/c=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
- State encoding: IDLE, APPLY, WAIT, CHECK, FINISH.
- IDLE:
  - start=1 -> APPLY with idx=0.
  - On that same edge, clear err_count, pass, first_fail_valid and first_fail_vec.
  - start=0 -> stay in IDLE; results from the previous run stay held.
- APPLY (1 cycle):
  - drv_{a,b,c} = idx[2], idx[1], idx[0]; registered and visible throughout APPLY.
  - The drives stay stable through WAIT and CHECK.
  - Next state is WAIT, or CHECK if SETTLE_CYCLES=0.
- WAIT: lasts exactly SETTLE_CYCLES cycles (internal down-counter), then -> CHECK.
- CHECK (1 cycle):
  - At the closing edge, compare dut_d against drv_a&drv_b and dut_e against drv_a&drv_b&drv_c.
  - Any mismatch: err_count+1. If first_fail_valid=0, also set first_fail_vec=idx and first_fail_valid=1.
  - If idx=7 -> FINISH; otherwise idx+1 -> APPLY.
- FINISH (1 cycle):
  - done=1, busy=1.
  - pass=(err_count==0), registered at the exit edge and held.
  - Next state is IDLE. drv_* return to 0 on entering IDLE.
- Timing:
  - Start accepted at edge T0 -> first APPLY cycle follows.
  - Each vector takes 2+SETTLE_CYCLES cycles.
  - done is high in cycle 8*(2+SETTLE_CYCLES)+1 after T0; with the default that is cycle 33.
- start while busy is ignored, with no effect on idx or counters.
- start held high continuously: a new run is accepted on the first IDLE cycle after FINISH (one idle cycle between runs).
- err_count never exceeds 8; no saturation logic is needed.
- dut_d/dut_e are sampled only in CHECK; glitches in other states are ignored.

Test Plan:
- Correct gate model, SETTLE_CYCLES=2, start pulse -> drv sequence 000..111, done at cycle 33, err_count=0, pass=1, first_fail_valid=0.
- dut_e stuck-0 -> err_count=1, first_fail_vec=3'b111, first_fail_valid=1, pass=0.
- dut_d stuck-1 -> mismatches at idx 0..5, err_count=6, first_fail_vec=3'b000, pass=0.
- Extra start pulses during APPLY/WAIT/CHECK of vector 3 -> no restart; done still at cycle 33 and results identical to the correct-model run.
- rst=1 in WAIT of vector 4 -> next cycle IDLE with all outputs 0. A following start -> full fresh run from idx=0 with correct results.
- SETTLE_CYCLES=0, correct model -> 2 cycles per vector, done at cycle 17, pass=1. start held high -> second run begins one cycle after FINISH, and pass/err_count are cleared on its accept edge.
